// File: rtl/counter_pkg.sv
// Shared constants and elaboration-time helpers for the BCD up/down counter.
// Holds the parameter-legality checks and the binary-to-BCD constant conversion.
package counter_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // Packs a binary value into MAX_DIGITS BCD digits, digit 0 in bits [3:0].
  function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int value);
    logic [BCD_W*MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(input int digits);
    return (digits >= 1) && (digits <= MAX_DIGITS);
  endfunction

  function automatic bit mod_ok(input int digits, input int modulus);
    return (modulus >= 2) && (modulus <= pow10(digits));
  endfunction

  function automatic bit tick_div_ok(input int tick_div);
    return tick_div >= 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: emits a registered one-cycle tick every TICK_DIV clocks.
// TICK_DIV = 1 degenerates to tick held high after reset release.
module tick_gen
  import counter_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  if (!tick_div_ok(TICK_DIV)) begin : g_bad_tick_div
    $error("tick_gen: TICK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (div == LAST);
      div  <= (div == LAST) ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Modulo-MOD BCD up/down counter advanced by a divided clock-enable tick.
// Priority per cycle: clear, then load (checked), then tick step, else hold.
module bcd_updown_counter
  import counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int MOD      = 10000,
  parameter int TICK_DIV = 10_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    stop,
  input  logic                    rev,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    tick,
  output logic                    wrap,
  output logic                    load_err
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [BCD_W*MAX_DIGITS-1:0] MAX_ALL = to_bcd(MOD - 1);
  localparam logic [W-1:0] MAX_BCD = MAX_ALL[W-1:0];

  if (!digits_ok(DIGITS)) begin : g_bad_digits
    $error("bcd_updown_counter: DIGITS must be in 1..8");
  end
  if (!mod_ok(DIGITS, MOD)) begin : g_bad_mod
    $error("bcd_updown_counter: MOD must be in 2..10**DIGITS");
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         carry;
  logic         borrow;
  logic         digits_valid;
  logic         load_ok;
  logic [W-1:0] bcd_nxt;
  logic         wrap_nxt;
  logic         err_nxt;

  // Ripple carry/borrow digit by digit; a digit only changes while the chain is live.
  always_comb begin
    inc_val = bcd;
    dec_val = bcd;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd[i*BCD_W +: BCD_W] == 4'd9) begin
          inc_val[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          inc_val[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (bcd[i*BCD_W +: BCD_W] == 4'd0) begin
          dec_val[i*BCD_W +: BCD_W] = 4'd9;
        end else begin
          dec_val[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // With every digit legal, BCD ordering equals unsigned ordering of the vector.
  always_comb begin
    digits_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[i*BCD_W +: BCD_W] > 4'd9) begin
        digits_valid = 1'b0;
      end
    end
    load_ok = digits_valid && (load_val <= MAX_BCD);
  end

  always_comb begin
    bcd_nxt  = bcd;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (clear) begin
      bcd_nxt = '0;
    end else if (load) begin
      if (load_ok) begin
        bcd_nxt = load_val;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (tick && !stop) begin
      if (!rev) begin
        if (bcd == MAX_BCD) begin
          bcd_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          bcd_nxt = inc_val;
        end
      end else begin
        if (bcd == '0) begin
          bcd_nxt  = MAX_BCD;
          wrap_nxt = 1'b1;
        end else begin
          bcd_nxt = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd      <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      bcd      <= bcd_nxt;
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

endmodule
